inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h00000000, giving the PC value loaded on reset.
REQ-002 The block SHALL have a parameter ROM_DEPTH_LOG2, default 8, giving the number of word-index bits the instruction ROM decodes (Addr[ROM_DEPTH_LOG2+1:2]).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Stall, input, 1 bit: hold PC and IF/ID contents this cycle.
REQ-006 The block SHALL have port Redirect, input, 1 bit: taken branch or jump resolved downstream.
REQ-007 The block SHALL have port Target, input, 32 bits: redirect address.
REQ-008 The block SHALL have port Addr, output, 32 bits: current PC, driven to InstROM Addr.
REQ-009 The block SHALL have port Inst, input, 32 bits: combinational InstROM read data for Addr.
REQ-010 The block SHALL have port IfIdInst, output, 32 bits: registered instruction to decode.
REQ-011 The block SHALL have port IfIdPC4, output, 32 bits: registered PC+4 of that instruction.
REQ-012 The block SHALL have port IfIdValid, output, 1 bit: IfIdInst holds a real instruction.
REQ-013 The block SHALL have port MisalignErr, output, 1 bit: one-cycle pulse when Target[1:0] != 0 at an accepted redirect.

Function
REQ-014 The FSM SHALL have states BOOT (first cycle after reset) and RUN.
REQ-015 The FSM SHALL move BOOT->RUN unconditionally after one cycle and SHALL stay in RUN until Reset.
REQ-016 In BOOT, the block SHALL hold PC and keep IfIdValid=0, so the first instruction appears in IF/ID on the 2nd edge after reset release.
REQ-017 In RUN, PC update priority SHALL be: Redirect > Stall > sequential (PC <= PC+4, 32-bit modulo wrap, 32'hFFFFFFFC -> 0).
REQ-018 On Redirect, PC SHALL load {Target[31:2],2'b00} and IF/ID SHALL load a bubble (IfIdInst=0, IfIdPC4=0, IfIdValid=0), even if Stall=1.
REQ-019 On Stall without Redirect, PC and all IfId* outputs SHALL hold their values.
REQ-020 On a sequential step, IfIdInst<=Inst, IfIdPC4<=PC+4 and IfIdValid<=1 on the same edge; fetch latency is 1 cycle from Addr to IfId*.
REQ-021 MisalignErr SHALL be 1 in the cycle after a redirect edge whose Target[1:0]!=0, and 0 otherwise.
REQ-022 Addr SHALL equal PC combinationally; the block SHALL NOT check Addr against ROM depth, and addresses beyond 4*2^ROM_DEPTH_LOG2 alias per ROM decoding.

Reset
REQ-023 When Reset=1 at a rising edge, then PC=RESET_PC, state=BOOT, IfIdInst=0, IfIdPC4=0, IfIdValid=0 and MisalignErr=0.
REQ-024 Reset SHALL override Redirect and Stall in the same cycle.
REQ-025 Reset asserted mid-stream SHALL discard any in-flight IF/ID contents.

Configuration
REQ-026 With INST_FETCH_PERF_EN defined, the block SHALL add 32-bit outputs FetchCnt and StallCnt.
REQ-027 FetchCnt SHALL increment on each edge that loads IfIdValid=1.
REQ-028 StallCnt SHALL increment on each RUN edge with Stall=1 and Redirect=0.
REQ-029 FetchCnt and StallCnt SHALL reset to 0 and wrap modulo 2^32.
REQ-030 Without INST_FETCH_PERF_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 The shared package cpu_pkg SHALL hold the FSM state typedef (FETCH_BOOT, FETCH_RUN), the NOP/bubble constant 32'h00000000 and the PC increment constant 4.
REQ-032 One sub-module, pc_reg (PC register with load/hold/increment), SHALL be used; the IF/ID register stays inline.

Verification
REQ-033 Reset test: Reset for 2 cycles, release -> Addr=0, IfIdValid=0 for 1 cycle, then IfIdInst=32'h00430820 with IfIdPC4=4.
REQ-034 Sequential test: ROM words 0..4 loaded, no stall -> IfIdInst sequence 00430820, 00232022, 00294023, 3426800A, 0025182A with Addr 0,4,8,C,10.
REQ-035 Stall test: Stall=1 for 3 cycles at Addr=8 -> Addr stays 8 and IfIdInst stays 00232022; resume -> next 00294023.
REQ-036 Redirect test: Redirect=1 with Target=32'h00000004 and Stall=1 simultaneously -> next Addr=4, IfIdValid=0; following cycle IfIdInst=00232022.
REQ-037 Misalign test: Redirect with Target=32'h0000000E -> Addr=C and MisalignErr=1 for exactly 1 cycle.
REQ-038 Wrap/perf test: RESET_PC=32'hFFFFFFFC -> Addr wraps to 0; with INST_FETCH_PERF_EN, 5 fetches and 3 stalls -> FetchCnt=5, StallCnt=3.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Types and constants shared by the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [0:0] {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with word-aligned load, hold and +4 step.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q + PC_INCR;
    if (load) begin
      pc_d = {load_pc[31:2], 2'b00};
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage with IF/ID pipeline register.
//               Define INST_FETCH_PERF_EN to add FetchCnt/StallCnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          ROM_DEPTH_LOG2 = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  output logic [31:0] IfIdInst,
  output logic [31:0] IfIdPC4,
  output logic        IfIdValid,
  output logic        MisalignErr
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic [31:0]  ifid_inst_q, ifid_inst_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         misalign_q, misalign_d;
  logic         pc_load, pc_hold;
  logic         run, seq_step;

  // The ROM decodes only these bits; higher address bits alias by design.
  logic [ROM_DEPTH_LOG2-1:0] unused_rom_index;
  assign unused_rom_index = pc[ROM_DEPTH_LOG2+1:2];

  assign run      = (state_q == FETCH_RUN);
  assign seq_step = run && !Redirect && !Stall;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (Clk),
    .rst     (Reset),
    .load    (pc_load),
    .hold    (pc_hold),
    .load_pc (Target),
    .pc      (pc)
  );

  always_comb begin
    state_d      = FETCH_RUN;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = 1'b0;
    pc_load      = 1'b0;
    pc_hold      = 1'b1;
    if (run && Redirect) begin
      // Redirect beats Stall: squash whatever sits in IF/ID.
      pc_load      = 1'b1;
      ifid_inst_d  = NOP_INST;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
      misalign_d   = |Target[1:0];
    end else if (seq_step) begin
      pc_hold      = 1'b0;
      ifid_inst_d  = Inst;
      ifid_pc4_d   = pc + PC_INCR;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= FETCH_BOOT;
      ifid_inst_q  <= NOP_INST;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign Addr        = pc;
  assign IfIdInst    = ifid_inst_q;
  assign IfIdPC4     = ifid_pc4_q;
  assign IfIdValid   = ifid_valid_q;
  assign MisalignErr = misalign_q;

`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, seq_step};
    stall_cnt_d = stall_cnt_q + {31'd0, run && Stall && !Redirect};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] target;
  logic [31:0] addr, inst, ifid_inst, ifid_pc4;
  logic        ifid_valid, mis_err;
  logic [31:0] addr2, inst2, ifid_inst2, ifid_pc42;
  logic        ifid_valid2, mis_err2;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

  logic [31:0] rom [0:255];
  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_inst, m_pc4, m_fc, m_sc;
  bit          m_boot, m_valid, m_mis;

  always #5 clk = ~clk;

  assign inst  = rom[addr[9:2]];
  assign inst2 = rom[addr2[9:2]];

  inst_fetch #(.RESET_PC(32'h0000_0000), .ROM_DEPTH_LOG2(8)) dut (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redirect), .Target(target),
    .Addr(addr), .Inst(inst), .IfIdInst(ifid_inst), .IfIdPC4(ifid_pc4),
    .IfIdValid(ifid_valid), .MisalignErr(mis_err)
`ifdef INST_FETCH_PERF_EN
    , .FetchCnt(fetch_cnt), .StallCnt(stall_cnt)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .ROM_DEPTH_LOG2(8)) dut_wrap (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redirect), .Target(target),
    .Addr(addr2), .Inst(inst2), .IfIdInst(ifid_inst2), .IfIdPC4(ifid_pc42),
    .IfIdValid(ifid_valid2), .MisalignErr(mis_err2)
`ifdef INST_FETCH_PERF_EN
    , .FetchCnt(fetch_cnt2), .StallCnt(stall_cnt2)
`endif
  );

  // Drive inputs for one cycle and advance the reference model across the edge.
  task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_boot = 1; m_inst = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      m_fc = 0; m_sc = 0;
    end else if (m_boot) begin
      m_boot = 0; m_mis = 0;
    end else if (rd) begin
      m_mis = (t % 4) != 0;
      m_pc = t - (t % 4);
      m_inst = 0; m_pc4 = 0; m_valid = 0;
    end else if (s) begin
      m_mis = 0; m_sc = m_sc + 1;
    end else begin
      m_mis = 0;
      m_inst = rom[(m_pc / 4) % 256];
      m_pc = m_pc + 4;
      m_pc4 = m_pc;
      m_valid = 1;
      m_fc = m_fc + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 32'h20);
    cycle(1, 0, 0, 0);
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr, 32'h0); end
    total++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0 || mis_err !== 1'b0) begin
      bad++; $display("FAIL reset_ifid got=%b/%h/%h/%b exp=0/0/0/0", ifid_valid, ifid_inst, ifid_pc4, mis_err); end
    cycle(0, 0, 0, 0);
    total++; if (addr !== 32'h0 || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL boot_hold got=%h/%b exp=0/0", addr, ifid_valid); end
    cycle(0, 0, 0, 0);
    total++; if (ifid_inst !== 32'h00430820 || ifid_pc4 !== 32'd4 || ifid_valid !== 1'b1) begin
      bad++; $display("FAIL first_fetch got=%h/%h/%b exp=00430820/4/1", ifid_inst, ifid_pc4, ifid_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [5];
    exp_inst[0] = 32'h00430820; exp_inst[1] = 32'h00232022; exp_inst[2] = 32'h00294023;
    exp_inst[3] = 32'h3426800A; exp_inst[4] = 32'h0025182A;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      total++; if (addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, addr, 32'(4 * i)); end
      cycle(0, 0, 0, 0);
      total++; if (ifid_inst !== exp_inst[i] || ifid_pc4 !== 32'(4 * i + 4)) begin
        bad++; $display("FAIL seq_inst%0d got=%h/%h exp=%h/%h", i, ifid_inst, ifid_pc4, exp_inst[i], 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      total++; if (addr !== 32'h8 || ifid_inst !== 32'h00232022 || ifid_valid !== 1'b1) begin
        bad++; $display("FAIL stall%0d got=%h/%h/%b exp=8/00232022/1", i, addr, ifid_inst, ifid_valid); end
    end
    cycle(0, 0, 0, 0);
    total++; if (ifid_inst !== 32'h00294023 || addr !== 32'hC) begin
      bad++; $display("FAIL stall_resume got=%h/%h exp=00294023/c", ifid_inst, addr); end
  endtask

  task automatic test_redirect();
    cycle(0, 1, 1, 32'h4);
    total++; if (addr !== 32'h4 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc4 !== 32'h0) begin
      bad++; $display("FAIL redirect got=%h/%b/%h/%h exp=4/0/0/0", addr, ifid_valid, ifid_inst, ifid_pc4); end
    total++; if (mis_err !== 1'b0) begin bad++; $display("FAIL redirect_mis got=%b exp=0", mis_err); end
    cycle(0, 0, 0, 0);
    total++; if (ifid_inst !== 32'h00232022 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h8) begin
      bad++; $display("FAIL redirect_fetch got=%h/%b/%h exp=00232022/1/8", ifid_inst, ifid_valid, ifid_pc4); end
  endtask

  task automatic test_misalign();
    cycle(0, 0, 1, 32'hE);
    total++; if (addr !== 32'hC || mis_err !== 1'b1) begin
      bad++; $display("FAIL misalign got=%h/%b exp=c/1", addr, mis_err); end
    cycle(0, 0, 0, 0);
    total++; if (mis_err !== 1'b0 || addr !== 32'h10) begin
      bad++; $display("FAIL misalign_pulse got=%b/%h exp=0/10", mis_err, addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    total++; if (addr2 !== 32'hFFFF_FFFC || ifid_valid2 !== 1'b0) begin
      bad++; $display("FAIL wrap_reset got=%h/%b exp=fffffffc/0", addr2, ifid_valid2); end
    cycle(0, 0, 0, 0);
    total++; if (addr2 !== 32'h0 || ifid_pc42 !== 32'h0 || ifid_inst2 !== rom[255] || ifid_valid2 !== 1'b1) begin
      bad++; $display("FAIL wrap got=%h/%h/%h exp=0/0/%h", addr2, ifid_pc42, ifid_inst2, rom[255]); end
  endtask

  task automatic test_perf();
`ifdef INST_FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    total++; if (fetch_cnt !== 32'd5 || stall_cnt !== 32'd3) begin
      bad++; $display("FAIL perf got=%0d/%0d exp=5/3", fetch_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit r, s, rd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 6) == 0);
      t  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
      cycle(r, s, rd, t);
      total++; if (addr !== m_pc || ifid_inst !== m_inst || ifid_pc4 !== m_pc4 ||
                   ifid_valid !== m_valid || mis_err !== m_mis) begin
        bad++; $display("FAIL rand%0d got=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/%b", i, addr, ifid_inst,
                        ifid_pc4, ifid_valid, mis_err, m_pc, m_inst, m_pc4, m_valid, m_mis); end
`ifdef INST_FETCH_PERF_EN
      total++; if (fetch_cnt !== m_fc || stall_cnt !== m_sc) begin
        bad++; $display("FAIL rand_perf%0d got=%0d/%0d exp=%0d/%0d", i, fetch_cnt, stall_cnt, m_fc, m_sc); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h00430820; rom[1] = 32'h00232022; rom[2] = 32'h00294023;
    rom[3] = 32'h3426800A; rom[4] = 32'h0025182A;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    test_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
